display_driver: RTL and testbench

- Drives a HUB75-style RGB LED matrix panel using binary code modulation (BCM) for intensity.
- Scans rows and bit planes in sequence. For each plane it fetches pixels from an external frame memory via row/column addresses, shifts one bit per colour into the panel, latches, then enables output for a time weighted by the bit significance.
- Sits between the frame buffer and the panel pins.

---
 rtl/display_driver_pkg.sv | 27 ++
 rtl/display_bcm_timer.sv | 30 +++
 rtl/display_driver.sv | 170 +++++++++++++++++
 tb/tb_display_driver.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_driver_pkg.sv
// Shared types and sizing helpers for the HUB75 BCM display driver.
// Provides the scan state enum and width calculations used by the top and timer.
package display_driver_pkg;

    typedef enum logic [1:0] {
        SHIFT,
        LATCH,
        DISPLAY,
        FRAME_END
    } state_t;

    // Address width that never collapses to zero bits.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the shift-phase cycle counter (0 .. 2*columns).
    function automatic int shift_width(input int columns);
        return $clog2(2 * columns + 1);
    endfunction

    // Width that holds the longest on-time, cyclewidth << (bitwidth-1).
    function automatic int timer_width(input int cyclewidth, input int bitwidth);
        return $clog2((cyclewidth << (bitwidth - 1)) + 1);
    endfunction

endpackage

// File: rtl/display_bcm_timer.sv
// Loadable down-counter timing the output-enable window of one bit plane.
// Ports: clk, rst (async high), load + value start a window, done marks its last cycle.
module display_bcm_timer #(
    parameter int width = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [width-1:0] value,
    output logic             done
);

    localparam logic [width-1:0] one = width'(1);

    logic [width-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - one;
        end
    end

    // A window of N cycles sees count = N .. 1; the cycle holding 1 is the last.
    assign done = (count == one);

endmodule

// File: rtl/display_driver.sv
// HUB75 RGB matrix driver using binary code modulation over bitwidth planes.
// Ports: clk, rst (async high); row/column fetch addresses and pixel data in
// (one cycle latency); rgb/oclk/lat/oe panel pins; frame_complete end-of-frame pulse.
module display_driver
    import display_driver_pkg::*;
#(
    parameter int segments   = 1,
    parameter int rows       = 8,
    parameter int columns    = 32,
    parameter int bitwidth   = 8,
    parameter int cyclewidth = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                frame_complete,
    output logic [addr_width(rows)-1:0]         row,
    output logic [addr_width(columns)-1:0]      column,
    input  logic [3*bitwidth*segments-1:0]      pixel,
    output logic [3*segments-1:0]               rgb,
    output logic                                oe,
    output logic                                lat,
    output logic                                oclk
);

    localparam int row_w   = addr_width(rows);
    localparam int col_w   = addr_width(columns);
    localparam int plane_w = addr_width(bitwidth);
    localparam int cnt_w   = shift_width(columns);
    localparam int tw      = timer_width(cyclewidth, bitwidth);

    localparam logic [cnt_w-1:0]   shift_last = cnt_w'(2 * columns);
    localparam logic [col_w-1:0]   col_last   = col_w'(columns - 1);
    localparam logic [row_w-1:0]   row_last   = row_w'(rows - 1);
    localparam logic [plane_w-1:0] plane_last = plane_w'(bitwidth - 1);

    state_t               state, state_n;
    logic [cnt_w-1:0]     shift_cnt, shift_n;
    logic [plane_w-1:0]   plane, plane_n;
    logic [row_w-1:0]     row_n;
    logic [col_w-1:0]     column_n;
    logic                 oe_n, lat_n, oclk_n, fc_n;
    logic                 load;
    logic                 timer_done;
    logic [tw-1:0]        timer_value;
    logic [3*segments-1:0] rgb_live, rgb_hold;
    logic                 phase_a;

    // Odd shift counts are the data-setup half of each column.
    assign phase_a = (state == SHIFT) && shift_cnt[0];

    for (genvar s = 0; s < segments; s++) begin : g_seg
        logic [bitwidth-1:0] red, green, blue;
        assign red   = pixel[3*bitwidth*s + 2*bitwidth +: bitwidth];
        assign green = pixel[3*bitwidth*s + bitwidth +: bitwidth];
        assign blue  = pixel[3*bitwidth*s +: bitwidth];
        assign rgb_live[3*s +: 3] = {red[plane], green[plane], blue[plane]};
    end

    // Data is taken straight from memory in the setup half and held
    // through the oclk-high half so the panel samples a stable value.
    always_comb begin
        rgb = '0;
        if (phase_a) begin
            rgb = rgb_live;
        end else if (oclk) begin
            rgb = rgb_hold;
        end
    end

    assign timer_value = tw'(cyclewidth) << plane;

    display_bcm_timer #(
        .width(tw)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (timer_value),
        .done  (timer_done)
    );

    always_comb begin
        state_n  = state;
        shift_n  = shift_cnt;
        plane_n  = plane;
        row_n    = row;
        column_n = column;
        load     = 1'b0;
        unique case (state)
            SHIFT: begin
                if (shift_cnt == shift_last) begin
                    state_n  = LATCH;
                    shift_n  = '0;
                    column_n = '0;
                end else begin
                    shift_n = shift_cnt + 1'b1;
                    // Step the fetch address on entry to each setup half,
                    // one cycle ahead of the data it returns.
                    if (!shift_cnt[0] && column != col_last) begin
                        column_n = column + 1'b1;
                    end
                end
            end
            LATCH: begin
                state_n = DISPLAY;
                load    = 1'b1;
            end
            DISPLAY: begin
                if (timer_done) begin
                    if (plane != plane_last) begin
                        plane_n = plane + 1'b1;
                        state_n = SHIFT;
                    end else begin
                        plane_n = '0;
                        if (row == row_last) begin
                            state_n = FRAME_END;
                        end else begin
                            row_n   = row + 1'b1;
                            state_n = SHIFT;
                        end
                    end
                end
            end
            FRAME_END: begin
                row_n   = '0;
                state_n = SHIFT;
            end
            default: begin
                state_n = SHIFT;
            end
        endcase
    end

    // Panel strobes are registered from the next state so the pins are glitch free.
    always_comb begin
        oe_n   = (state_n == DISPLAY);
        lat_n  = (state_n == LATCH);
        fc_n   = (state_n == FRAME_END);
        oclk_n = (state_n == SHIFT) && (shift_n != '0) && !shift_n[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= SHIFT;
            shift_cnt      <= '0;
            plane          <= '0;
            row            <= '0;
            column         <= '0;
            rgb_hold       <= '0;
            oe             <= 1'b0;
            lat            <= 1'b0;
            oclk           <= 1'b0;
            frame_complete <= 1'b0;
        end else begin
            state          <= state_n;
            shift_cnt      <= shift_n;
            plane          <= plane_n;
            row            <= row_n;
            column         <= column_n;
            oe             <= oe_n;
            lat            <= lat_n;
            oclk           <= oclk_n;
            frame_complete <= fc_n;
            if (phase_a) begin
                rgb_hold <= rgb_live;
            end
        end
    end

endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench for display_driver: default single-segment panel plus
// a small two-segment instance, against a plane-level reference model.
module tb_display_driver;

    localparam int R0 = 8;
    localparam int C0 = 32;
    localparam int BW0 = 8;
    localparam int CW0 = 10;
    localparam int FRAME0 = R0 * (BW0 * (2 * C0 + 2) + CW0 * ((1 << BW0) - 1)) + 1;
    localparam int ROW_ON0 = CW0 * ((1 << BW0) - 1);

    localparam int S1 = 2;
    localparam int R1 = 2;
    localparam int C1 = 4;
    localparam int BW1 = 3;
    localparam int CW1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        fc0, oe0, lat0, oclk0;
    logic [2:0]  row0;
    logic [4:0]  col0;
    logic [23:0] pix0;
    logic [2:0]  rgb0;
    logic        fc1, oe1, lat1, oclk1;
    logic [0:0]  row1;
    logic [1:0]  col1;
    logic [17:0] pix1;
    logic [5:0]  rgb1;

    logic [23:0] fb0 [R0][C0];
    logic [17:0] fb1 [R1][C1];

    int checks = 0;
    int errors = 0;

    display_driver u_dut0 (
        .clk(clk), .rst(rst0), .frame_complete(fc0), .row(row0),
        .column(col0), .pixel(pix0), .rgb(rgb0), .oe(oe0),
        .lat(lat0), .oclk(oclk0)
    );

    display_driver #(
        .segments(S1), .rows(R1), .columns(C1),
        .bitwidth(BW1), .cyclewidth(CW1)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .frame_complete(fc1), .row(row1),
        .column(col1), .pixel(pix1), .rgb(rgb1), .oe(oe1),
        .lat(lat1), .oclk(oclk1)
    );

    // Frame memories with one cycle of read latency.
    always @(posedge clk) pix0 <= fb0[row0][col0];
    always @(posedge clk) pix1 <= fb1[row1][col1];

    // One record per bit plane of the default instance.
    typedef struct {
        int          row;
        int          nclk;
        logic [95:0] bits;
        int          oe_len;
        int          lat_n;
    } rec_t;

    rec_t       recs[$];
    rec_t       cur;
    int         edges;
    int         fc_first;
    int         viol;
    logic [2:0] rgb_or;
    logic       p_oclk, p_oe;

    always @(negedge clk) begin
        if (rst0) begin
            recs.delete();
            cur = '{default: 0};
            edges = 0;
            fc_first = -1;
            viol = 0;
            rgb_or = '0;
            p_oclk = 1'b0;
            p_oe = 1'b0;
        end else begin
            edges++;
            rgb_or = rgb_or | rgb0;
            if (oclk0 && !p_oclk) begin
                if (int'(col0) != ((cur.nclk + 1 < C0) ? cur.nclk + 1 : C0 - 1)) viol++;
                if (cur.nclk < C0) cur.bits[3*cur.nclk +: 3] = rgb0;
                cur.nclk++;
                cur.row = int'(row0);
            end
            if (lat0) cur.lat_n++;
            if (oe0) begin
                cur.oe_len++;
                if (int'(row0) != cur.row) viol++;
            end
            if (oe0 && lat0) viol++;
            if (oe0 && (oclk0 || oclk0 != p_oclk)) viol++;
            if (fc0 && (oe0 || lat0)) viol++;
            if (!oe0 && p_oe) begin
                recs.push_back(cur);
                cur = '{default: 0};
            end
            if (fc0 && fc_first < 0) fc_first = edges;
            p_oclk = oclk0;
            p_oe = oe0;
        end
    end

    // Expected shifted bits of one plane: channel bit 'p' of every column.
    function automatic logic [95:0] exp_bits(input int r, input int p);
        logic [95:0] v;
        logic [23:0] px;
        v = '0;
        for (int c = 0; c < C0; c++) begin
            px = fb0[r][c];
            v[3*c +: 3] = {px[16+p], px[8+p], px[p]};
        end
        return v;
    endfunction

    function automatic logic [5:0] exp_seg(input int r, input int c, input int p);
        logic [5:0]  v;
        logic [17:0] px;
        px = fb1[r][c];
        v = '0;
        for (int s = 0; s < S1; s++) begin
            v[3*s +: 3] = {px[9*s+6+p], px[9*s+3+p], px[9*s+p]};
        end
        return v;
    endfunction

    task automatic fill0_const(input logic [23:0] v);
        for (int r = 0; r < R0; r++)
            for (int c = 0; c < C0; c++) fb0[r][c] = v;
    endtask

    task automatic fill0_rand();
        for (int r = 0; r < R0; r++)
            for (int c = 0; c < C0; c++) fb0[r][c] = 24'($urandom);
    endtask

    task automatic reset0();
        @(negedge clk);
        rst0 = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst0 = 1'b0;
    endtask

    task automatic wait_fc0(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(posedge clk);
            ok = (fc_first >= 0);
        end
    endtask

    task automatic wait_recs0(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(posedge clk);
            ok = (recs.size() >= n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({fc0, oe0, lat0, oclk0, rgb0, row0, col0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: outputs %b want 0",
                     {fc0, oe0, lat0, oclk0, rgb0, row0, col0});
        end
        checks++;
        if ({fc1, oe1, lat1, oclk1, rgb1, row1, col1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: outputs %b want 0",
                     {fc1, oe1, lat1, oclk1, rgb1, row1, col1});
        end
    endtask

    task automatic test_all_ones();
        bit ok;
        int sum;
        fill0_const(24'hFFFFFF);
        reset0();
        wait_fc0(FRAME0 + 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ones_fc_timeout: frame_complete never seen");
        end
        // The release cycle is the first of the frame; FRAME_END is its last.
        checks++;
        if (fc_first !== FRAME0 - 1) begin
            errors++;
            $display("FAIL ones_fc_cycle: got %0d want %0d", fc_first, FRAME0 - 1);
        end
        checks++;
        if (fc_first < 0 || 48000000 / (fc_first + 1) < 60) begin
            errors++;
            $display("FAIL ones_rate: frame cycles %0d below 60 Hz", fc_first + 1);
        end
        checks++;
        if (recs.size() !== R0 * BW0) begin
            errors++;
            $display("FAIL ones_planes: got %0d want %0d", recs.size(), R0 * BW0);
        end
        for (int r = 0; r < R0; r++) begin
            sum = 0;
            for (int p = 0; p < BW0; p++)
                if (r * BW0 + p < recs.size()) sum += recs[r*BW0+p].oe_len;
            checks++;
            if (sum !== ROW_ON0) begin
                errors++;
                $display("FAIL ones_row_on r%0d: got %0d want %0d", r, sum, ROW_ON0);
            end
        end
        for (int k = 0; k < recs.size(); k++) begin
            checks++;
            if (recs[k].row !== k / BW0 || recs[k].nclk !== C0 ||
                recs[k].lat_n !== 1 || recs[k].oe_len !== (CW0 << (k % BW0)) ||
                recs[k].bits !== exp_bits(k / BW0, k % BW0)) begin
                errors++;
                $display("FAIL ones_plane k%0d: row %0d clk %0d lat %0d oe %0d bits %h",
                         k, recs[k].row, recs[k].nclk, recs[k].lat_n,
                         recs[k].oe_len, recs[k].bits);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL ones_protocol: %0d violations want 0", viol);
        end
    endtask

    task automatic test_zero();
        bit ok;
        fill0_const(24'h000000);
        reset0();
        wait_recs0(BW0, 4000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL zero_timeout: %0d planes seen", recs.size());
        end
        for (int k = 0; k < recs.size() && k < BW0; k++) begin
            checks++;
            if (recs[k].row !== 0 || recs[k].nclk !== C0 || recs[k].lat_n !== 1 ||
                recs[k].oe_len !== (CW0 << k) || recs[k].bits !== '0) begin
                errors++;
                $display("FAIL zero_plane p%0d: row %0d clk %0d lat %0d oe %0d bits %h",
                         k, recs[k].row, recs[k].nclk, recs[k].lat_n,
                         recs[k].oe_len, recs[k].bits);
            end
        end
        checks++;
        if (rgb_or !== 3'b000 || viol !== 0) begin
            errors++;
            $display("FAIL zero_rgb: rgb seen %b viol %0d want 000 and 0", rgb_or, viol);
        end
    endtask

    task automatic test_r_msb();
        bit ok;
        fill0_const(24'h800000);
        reset0();
        wait_recs0(BW0, 4000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmsb_timeout: %0d planes seen", recs.size());
        end
        for (int k = 0; k < recs.size() && k < BW0; k++) begin
            checks++;
            if (recs[k].nclk !== C0 || recs[k].oe_len !== (CW0 << k) ||
                recs[k].bits !== exp_bits(0, k)) begin
                errors++;
                $display("FAIL rmsb_plane p%0d: clk %0d oe %0d bits %h want %h",
                         k, recs[k].nclk, recs[k].oe_len, recs[k].bits, exp_bits(0, k));
            end
        end
        checks++;
        if (rgb_or[1:0] !== 2'b00 || rgb_or[2] !== 1'b1) begin
            errors++;
            $display("FAIL rmsb_channels: rgb seen %b want 100", rgb_or);
        end
    endtask

    task automatic test_random();
        bit ok;
        fill0_rand();
        reset0();
        wait_recs0(2 * BW0, 8000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rand_timeout: %0d planes seen", recs.size());
        end
        for (int k = 0; k < recs.size() && k < 2 * BW0; k++) begin
            checks++;
            if (recs[k].row !== k / BW0 || recs[k].nclk !== C0 ||
                recs[k].oe_len !== (CW0 << (k % BW0)) ||
                recs[k].bits !== exp_bits(k / BW0, k % BW0)) begin
                errors++;
                $display("FAIL rand_plane k%0d: row %0d clk %0d oe %0d bits %h want %h",
                         k, recs[k].row, recs[k].nclk, recs[k].oe_len,
                         recs[k].bits, exp_bits(k / BW0, k % BW0));
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL rand_protocol: %0d violations want 0", viol);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        fill0_rand();
        reset0();
        ok = 1'b0;
        for (int t = 0; t < 12000 && !ok; t++) begin
            @(posedge clk);
            #2 ok = (recs.size() >= 3 * BW0 + 5) && oe0;
        end
        checks++;
        if (!ok || row0 !== 3'd3) begin
            errors++;
            $display("FAIL midrst_reach: ok %0d row %0d want row 3 lit", ok, row0);
        end
        #1 rst0 = 1'b1;
        #1;
        checks++;
        if ({oe0, lat0, oclk0, fc0, rgb0, row0, col0} !== '0) begin
            errors++;
            $display("FAIL midrst_drop: outputs %b want 0",
                     {oe0, lat0, oclk0, fc0, rgb0, row0, col0});
        end
        reset0();
        wait_fc0(FRAME0 + 100, ok);
        checks++;
        if (!ok || fc_first !== FRAME0 - 1) begin
            errors++;
            $display("FAIL midrst_fc_cycle: got %0d want %0d", fc_first, FRAME0 - 1);
        end
        checks++;
        if (recs.size() !== R0 * BW0) begin
            errors++;
            $display("FAIL midrst_planes: got %0d want %0d", recs.size(), R0 * BW0);
        end
        for (int k = 0; k < recs.size(); k++) begin
            checks++;
            if (recs[k].row !== k / BW0 || recs[k].oe_len !== (CW0 << (k % BW0)) ||
                recs[k].bits !== exp_bits(k / BW0, k % BW0)) begin
                errors++;
                $display("FAIL midrst_plane k%0d: row %0d oe %0d bits %h",
                         k, recs[k].row, recs[k].oe_len, recs[k].bits);
            end
        end
    endtask

    task automatic test_segments();
        bit   got;
        logic p_oc;
        int   len, extra;
        for (int r = 0; r < R1; r++)
            for (int c = 0; c < C1; c++) fb1[r][c] = 18'($urandom);
        @(negedge clk);
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst1 = 1'b0;
        p_oc = 1'b0;
        for (int r = 0; r < R1; r++) begin
            for (int p = 0; p < BW1; p++) begin
                for (int c = 0; c < C1; c++) begin
                    got = 1'b0;
                    for (int t = 0; t < 100 && !got; t++) begin
                        @(negedge clk);
                        got = oclk1 && !p_oc;
                        p_oc = oclk1;
                    end
                    checks++;
                    if (!got || oe1 || int'(row1) != r || rgb1 !== exp_seg(r, c, p)) begin
                        errors++;
                        $display("FAIL seg_bit r%0d p%0d c%0d: rgb %b oe %b row %0d want %b",
                                 r, p, c, rgb1, oe1, row1, exp_seg(r, c, p));
                    end
                end
                got = 1'b0;
                extra = 0;
                for (int t = 0; t < 100 && !got; t++) begin
                    @(negedge clk);
                    if (oclk1 && !p_oc) extra++;
                    p_oc = oclk1;
                    got = lat1;
                end
                checks++;
                if (!got || oe1 || extra !== 0) begin
                    errors++;
                    $display("FAIL seg_latch r%0d p%0d: lat %b oe %b extra clk %0d",
                             r, p, got, oe1, extra);
                end
                len = 0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    p_oc = oclk1;
                    if (oe1) len++;
                    else break;
                end
                checks++;
                if (len !== (CW1 << p)) begin
                    errors++;
                    $display("FAIL seg_oe r%0d p%0d: got %0d want %0d", r, p, len, CW1 << p);
                end
            end
        end
        checks++;
        if (fc1 !== 1'b1) begin
            errors++;
            $display("FAIL seg_frame: frame_complete %b want 1", fc1);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        fill0_const(24'h000000);
        for (int r = 0; r < R1; r++)
            for (int c = 0; c < C1; c++) fb1[r][c] = '0;
        test_reset();
        test_all_ones();
        test_zero();
        test_r_msb();
        test_random();
        test_mid_reset();
        test_segments();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
